// File: rtl/fir_decim_buffer.sv
// Decimate-by-DECIM stage with an output FIFO drained over valid/ready.
// Optional macro DECIM_ACC_EN selects integrate-and-dump decimation instead of sample dropping.
module fir_decim_buffer #(
    parameter int unsigned DECIM      = 4,
    parameter int unsigned LOG2_DECIM = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        in_data,
    input  logic               in_valid,
    input  logic               phase_clr,
    output logic [15:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    input  logic               clr_overflow
);

    localparam int unsigned DW = 16;
    localparam int unsigned LW = FIFO_AW + 1;
    localparam logic [LOG2_DECIM-1:0] LAST_PHASE = LOG2_DECIM'(DECIM - 1);
    localparam logic [LW-1:0]         FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [LOG2_DECIM-1:0] phase_q;
    logic [LOG2_DECIM-1:0] phase_eff_c;
    logic [LOG2_DECIM-1:0] phase_d;
    logic                  push_req_c;
    logic [DW-1:0]         push_data_c;

    logic [DW-1:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr_q;
    logic [FIFO_AW-1:0]    rd_ptr_q;
    logic [FIFO_AW-1:0]    wr_ptr_d;
    logic [FIFO_AW-1:0]    rd_ptr_d;
    logic [LW-1:0]         level_d;
    logic [DW-1:0]         out_data_d;
    logic                  overflow_d;
    logic                  full_c;
    logic                  pop_c;
    logic                  push_c;
    logic                  ovf_event_c;

    // A phase_clr sample is handled as phase 0 in the same cycle.
    assign phase_eff_c = phase_clr ? '0 : phase_q;
    assign push_req_c  = in_valid && (phase_eff_c == LAST_PHASE);
    assign phase_d     = in_valid ? LOG2_DECIM'(phase_eff_c + 1'b1) : phase_eff_c;

`ifdef DECIM_ACC_EN
    localparam int unsigned AW = DW + LOG2_DECIM;

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] in_ext_c;
    logic signed [AW-1:0] sum_c;

    assign in_ext_c    = {{LOG2_DECIM{in_data[DW-1]}}, in_data};
    assign sum_c       = acc_q + in_ext_c;
    assign push_data_c = DW'(sum_c >>> LOG2_DECIM);

    always_comb begin
        acc_d = acc_q;
        if (in_valid) begin
            acc_d = (phase_eff_c == '0) ? in_ext_c : sum_c;
        end else if (phase_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign push_data_c = in_data;
`endif

    assign full_c      = (fifo_level == FULL_LEVEL);
    assign pop_c       = out_valid && out_ready;
    assign push_c      = push_req_c && (!full_c || pop_c);
    assign ovf_event_c = push_req_c && full_c && !pop_c;

    // Next FIFO state; the head word is looked up ahead so out_data stays registered.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = fifo_level;
        out_data_d = '0;
        overflow_d = overflow;

        if (push_c) wr_ptr_d = FIFO_AW'(wr_ptr_q + 1'b1);
        if (pop_c)  rd_ptr_d = FIFO_AW'(rd_ptr_q + 1'b1);

        case ({push_c, pop_c})
            2'b10:   level_d = LW'(fifo_level + 1'b1);
            2'b01:   level_d = LW'(fifo_level - 1'b1);
            default: level_d = fifo_level;
        endcase

        if (level_d != '0) begin
            if (push_c && (wr_ptr_q == rd_ptr_d)) begin
                out_data_d = push_data_c;
            end else begin
                out_data_d = mem[rd_ptr_d];
            end
        end

        if (ovf_event_c) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= push_data_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            overflow   <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_level <= level_d;
            out_valid  <= (level_d != '0);
            out_data   <= out_data_d;
            overflow   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Randomised bench for fir_decim_buffer against a queue-based reference model.
// Build with +define+DECIM_ACC_EN to exercise the integrate-and-dump variant.
module tb_fir_decim_buffer;

    localparam int unsigned DECIM      = 4;
    localparam int unsigned LOG2_DECIM = 2;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned FIFO_AW    = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [15:0]        in_data;
    logic               in_valid;
    logic               phase_clr;
    logic [15:0]        out_data;
    logic               out_valid;
    logic               out_ready;
    logic [FIFO_AW:0]   fifo_level;
    logic               overflow;
    logic               clr_overflow;

    always #5 clk = ~clk;

    fir_decim_buffer #(
        .DECIM      (DECIM),
        .LOG2_DECIM (LOG2_DECIM),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .phase_clr    (phase_clr),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: sample index within the decimation group, running sum, output queue.
    logic [15:0] q[$];
    int          m_phase = 0;
    int          m_sum   = 0;
    bit          m_ovf   = 1'b0;

`ifdef DECIM_ACC_EN
    localparam logic [15:0] EXP_FIRST  = 16'd2;
    localparam logic [15:0] EXP_SECOND = 16'd6;
`else
    localparam logic [15:0] EXP_FIRST  = 16'd4;
    localparam logic [15:0] EXP_SECOND = 16'd8;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [15:0] exp_d;
        exp_d = 16'd0;
        if (q.size() != 0) exp_d = q[0];
        check("out_valid",  32'(out_valid),  32'(q.size() != 0));
        check("out_data",   32'(out_data),   32'(exp_d));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("overflow",   32'(overflow),   32'(m_ovf));
    endtask

    task automatic model_reset();
        q.delete();
        m_phase = 0;
        m_sum   = 0;
        m_ovf   = 1'b0;
    endtask

    // Applies one clock edge worth of behaviour to the model.
    task automatic model_update();
        bit full;
        bit pop;
        bit push_req;
        int ph;
        int val;
        full     = (q.size() == FIFO_DEPTH);
        pop      = (q.size() != 0) && out_ready;
        push_req = 1'b0;
        val      = 0;
        ph       = phase_clr ? 0 : m_phase;
        if (phase_clr) m_sum = 0;
        if (in_valid) begin
            if (ph == 0) m_sum = int'($signed(in_data));
            else         m_sum = m_sum + int'($signed(in_data));
            if (ph == DECIM - 1) begin
                push_req = 1'b1;
`ifdef DECIM_ACC_EN
                val = m_sum >>> LOG2_DECIM;
`else
                val = int'($signed(in_data));
`endif
            end
            m_phase = (ph + 1) % DECIM;
        end else begin
            m_phase = ph;
        end
        if (pop) void'(q.pop_front());
        if (clr_overflow) m_ovf = 1'b0;
        if (push_req) begin
            if (!full || pop) q.push_back(16'(val));
            else              m_ovf = 1'b1;
        end
    endtask

    task automatic step(input logic iv, input logic [15:0] d, input logic pc,
                        input logic rdy, input logic co);
        in_valid     = iv;
        in_data      = d;
        phase_clr    = pc;
        out_ready    = rdy;
        clr_overflow = co;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic random_steps(input int n, input int rdy_pct);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 9) < 7, 16'($urandom),
                 $urandom_range(0, 31) == 0,
                 $urandom_range(0, 99) < rdy_pct,
                 $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; phase_clr = 1'b0;
        out_ready = 1'b0; clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b1;

        // Ramp 1..8 with consumer always ready.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b1, 1'b0);
            if (i == 4) check("ramp_first",  32'(out_data), 32'(EXP_FIRST));
            if (i == 8) check("ramp_second", 32'(out_data), 32'(EXP_SECOND));
        end
        repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Negative full-scale then positive full-scale groups.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i < 4) ? 16'hFFFF : 16'h7FFF, 1'b0, 1'b1, 1'b0);
            if (i == 3) check("neg_group", 32'(out_data), 32'h0000_FFFF);
            if (i == 7) check("pos_group", 32'(out_data), 32'h0000_7FFF);
        end
        repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Back-pressure: 40 samples into a stalled consumer overflow the FIFO.
        for (int i = 0; i < 40; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        check("sat_level", 32'(fifo_level), 32'(FIFO_DEPTH));
        check("sat_ovf",   32'(overflow),   32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);
        repeat (9) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("drained", 32'(fifo_level), 32'd0);

        // Push and pop on the same edge while full.
        for (int i = 0; i < 35; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0);
        check("full_pp_level", 32'(fifo_level), 32'(FIFO_DEPTH));
        check("full_pp_ovf",   32'(overflow),   32'd0);
        repeat (10) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // phase_clr at phase 2: next push after three more samples.
        repeat (2) step(1'b1, 16'($urandom), 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b1, 16'($urandom), 1'b0, 1'b1, 1'b0);
        check("pclr_no_push", 32'(out_valid), 32'd0);
        step(1'b1, 16'h0202, 1'b0, 1'b1, 1'b0);
        check("pclr_push", 32'(out_valid), 32'd1);
        repeat (2) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        random_steps(1500, 70);
        random_steps(800, 15);

        // Asynchronous reset mid-operation with data pending.
        for (int i = 0; i < 14; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_all();

        random_steps(1500, 50);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
